// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the auto-serialise FSM state type.
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } usr_state_t;

endpackage

// File: rtl/usr_shift_cnt.sv
// Saturating up-counter for the auto-serialiser: counts shifts in a word and
// flags the last one (count == WIDTH-1). Never wraps past WIDTH-1.
module usr_shift_cnt #(
   parameter int WIDTH = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (i_en && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign o_last = (cnt == LAST);

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register (hold/shl/shr/load, sync clear, enable) with an
// MSB-first auto-serialise FSM. Define USR_PARITY_EN to add the o_parity output.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_enable,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_sin_l,
   input  logic             i_sin_r,
   input  logic             i_start,
   output logic [WIDTH-1:0] o_q,
   output logic             o_sout_l,
   output logic             o_sout_r,
   output logic             o_ser,
   output logic             o_ser_valid,
   output logic             o_busy,
   output logic             o_done
`ifdef USR_PARITY_EN
   ,
   output logic             o_parity
`endif
);

   usr_state_t       state, state_next;
   logic [WIDTH-1:0] q, q_next;
   logic             cnt_clr, cnt_en, cnt_last;

   usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (cnt_clr),
      .i_en    (cnt_en),
      .o_last  (cnt_last)
   );

   // Priority: clear > freeze > SHIFT > start > mode.
   // NOTE: every signal gets a default first so this block can never infer a latch.
   always_comb begin
      q_next     = q;
      state_next = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      if (i_clr) begin
         q_next     = RST_VAL;
         state_next = ST_IDLE;
         cnt_clr    = 1'b1;
      end else if (i_enable) begin
         if (state == ST_SHIFT) begin
            q_next = {q[WIDTH-2:0], i_sin_r};
            cnt_en = 1'b1;
            if (cnt_last) state_next = ST_DONE;
         end else if (i_start) begin
            q_next     = i_d;
            cnt_clr    = 1'b1;
            state_next = ST_SHIFT;
         end else begin
            state_next = ST_IDLE;
            case (i_mode)
               MODE_SHL:  q_next = {q[WIDTH-2:0], i_sin_r};
               MODE_SHR:  q_next = {i_sin_l, q[WIDTH-1:1]};
               MODE_LOAD: q_next = i_d;
               default:   q_next = q;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q     <= RST_VAL;
         state <= ST_IDLE;
      end else begin
         q     <= q_next;
         state <= state_next;
      end
   end

`ifdef USR_PARITY_EN
   // Parity of the value being loaded, so it lines up with o_q in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_parity <= ^RST_VAL;
      else          o_parity <= ^q_next;
   end
`endif

   assign o_q         = q;
   assign o_sout_l    = q[WIDTH-1];
   assign o_sout_r    = q[0];
   assign o_ser       = q[WIDTH-1];
   assign o_busy      = (state == ST_SHIFT);
   assign o_ser_valid = (state == ST_SHIFT);
   assign o_done      = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;
   import usr_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst_n, i_clr, i_enable, i_sin_l, i_sin_r, i_start;
   logic [1:0] i_mode;
   logic [7:0] i_d;
   logic [7:0] o_q;
   logic       o_sout_l, o_sout_r, o_ser, o_ser_valid, o_busy, o_done;
`ifdef USR_PARITY_EN
   logic       o_parity;
`endif

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (i_clr),
      .i_enable    (i_enable),
      .i_mode      (i_mode),
      .i_d         (i_d),
      .i_sin_l     (i_sin_l),
      .i_sin_r     (i_sin_r),
      .i_start     (i_start),
      .o_q         (o_q),
      .o_sout_l    (o_sout_l),
      .o_sout_r    (o_sout_r),
      .o_ser       (o_ser),
      .o_ser_valid (o_ser_valid),
      .o_busy      (o_busy),
      .o_done      (o_done)
`ifdef USR_PARITY_EN
      ,
      .o_parity    (o_parity)
`endif
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] q;
      logic       vld;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errs   = 0;
   int   n_vld    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the expected post-edge state, advance one edge, then pop and compare.
   task automatic step(input string tag, input logic [7:0] q, input logic vld,
                       input logic busy, input logic done);
      exp_t e;
      sb.push_back('{q: q, vld: vld, busy: busy, done: done});
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      check({tag, ".q"},      32'(o_q),         32'(e.q));
      check({tag, ".vld"},    32'(o_ser_valid), 32'(e.vld));
      check({tag, ".busy"},   32'(o_busy),      32'(e.busy));
      check({tag, ".done"},   32'(o_done),      32'(e.done));
      check({tag, ".sout_r"}, 32'(o_sout_r),    32'(e.q[0]));
      if (e.vld) check({tag, ".ser"}, 32'(o_ser), 32'(e.q[7]));
`ifdef USR_PARITY_EN
      check({tag, ".par"}, 32'(o_parity), 32'(^e.q));
`endif
      if (o_ser_valid === 1'b1) n_vld++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] ser_bits;

      i_rst_n = 1'b0; i_clr = 1'b0; i_enable = 1'b1; i_mode = MODE_HOLD;
      i_d = 8'h00; i_sin_l = 1'b0; i_sin_r = 1'b0; i_start = 1'b0;
      #2;
      check("rst.q",    32'(o_q),         32'h00);
      check("rst.busy", 32'(o_busy),      32'h0);
      check("rst.vld",  32'(o_ser_valid), 32'h0);
      check("rst.done", 32'(o_done),      32'h0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // 1: asynchronous reset mid-cycle
      i_mode = MODE_LOAD; i_d = 8'hA5;
      step("t1_load", 8'hA5, 0, 0, 0);
      i_mode = MODE_HOLD;
      #3;
      i_rst_n = 1'b0;
      #1;
      check("t1_async.q", 32'(o_q), 32'h00);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // 2: mode operations
      i_mode = MODE_LOAD; i_d = 8'h81;
      step("t2_load", 8'h81, 0, 0, 0);
      check("t2_sout_l", 32'(o_sout_l), 32'h1);
      i_mode = MODE_SHL; i_sin_r = 1'b1;
      step("t2_shl1", 8'h03, 0, 0, 0);
      step("t2_shl2", 8'h07, 0, 0, 0);
      i_mode = MODE_SHR; i_sin_l = 1'b0; i_sin_r = 1'b0;
      step("t2_shr", 8'h03, 0, 0, 0);
      check("t2_sout_l0", 32'(o_sout_l), 32'h0);
      i_mode = MODE_HOLD;
      step("t2_hold", 8'h03, 0, 0, 0);

      // 3: auto-serialise B4, MSB first; mode is ignored while shifting
      ser_bits = 8'b1011_0100;
      n_vld = 0;
      i_start = 1'b1; i_d = 8'hB4;
      step("t3_start", 8'hB4, 1, 1, 0);
      check("t3_ser0", 32'(o_ser), 32'(ser_bits[7]));
      i_start = 1'b0; i_mode = MODE_SHR; i_sin_l = 1'b1;
      v = 8'hB4;
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) i_mode = MODE_HOLD;
         v = {v[6:0], 1'b0};
         step("t3_shift", v, k < 8, k < 8, k == 8);
         if (k < 8) check("t3_ser", 32'(o_ser), 32'(ser_bits[7-k]));
      end
      check("t3_vld_count", 32'(n_vld), 32'd8);
      i_sin_l = 1'b0;
      step("t3_idle", 8'h00, 0, 0, 0);

      // 4: freeze mid-SHIFT, then resume
      i_start = 1'b1; i_d = 8'hB4;
      step("t4_start", 8'hB4, 1, 1, 0);
      i_start = 1'b0;
      step("t4_sh1", 8'h68, 1, 1, 0);
      step("t4_sh2", 8'hD0, 1, 1, 0);
      i_enable = 1'b0; i_start = 1'b1;
      for (int k = 0; k < 3; k++) step("t4_frz", 8'hD0, 1, 1, 0);
      i_enable = 1'b1; i_start = 1'b0;
      v = 8'hD0;
      for (int k = 3; k <= 8; k++) begin
         v = {v[6:0], 1'b0};
         step("t4_shift", v, k < 8, k < 8, k == 8);
      end
      step("t4_idle", 8'h00, 0, 0, 0);
      // start while disabled is dropped, not queued
      i_enable = 1'b0; i_start = 1'b1; i_d = 8'hFF;
      step("t4_nostart", 8'h00, 0, 0, 0);
      i_enable = 1'b1; i_start = 1'b0;
      step("t4_noqueue", 8'h00, 0, 0, 0);

      // 5: clear at count 4 aborts, beats a low enable, and never pulses done
      i_start = 1'b1; i_d = 8'hB4;
      step("t5_start", 8'hB4, 1, 1, 0);
      i_start = 1'b0;
      v = 8'hB4;
      for (int k = 1; k <= 4; k++) begin
         v = {v[6:0], 1'b0};
         step("t5_shift", v, 1, 1, 0);
      end
      i_clr = 1'b1; i_enable = 1'b0;
      step("t5_clr", 8'h00, 0, 0, 0);
      i_clr = 1'b0; i_enable = 1'b1;
      step("t5_post1", 8'h00, 0, 0, 0);
      step("t5_post2", 8'h00, 0, 0, 0);

      // 6: back-to-back words through DONE
      n_vld = 0;
      i_start = 1'b1; i_d = 8'hB4;
      step("t6_start", 8'hB4, 1, 1, 0);
      i_start = 1'b0;
      v = 8'hB4;
      for (int k = 1; k <= 7; k++) begin
         v = {v[6:0], 1'b0};
         step("t6_w0", v, 1, 1, 0);
      end
      i_start = 1'b1; i_d = 8'h3C;
      step("t6_done0", 8'h00, 0, 0, 1);
      step("t6_restart", 8'h3C, 1, 1, 0);
      i_start = 1'b0;
      v = 8'h3C;
      for (int k = 1; k <= 8; k++) begin
         v = {v[6:0], 1'b0};
         step("t6_w1", v, k < 8, k < 8, k == 8);
      end
      check("t6_vld_count", 32'(n_vld), 32'd16);
      step("t6_idle", 8'h00, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
